// File: rtl/id_exe_stage.sv
// ID/EXE pipeline register: latches decoded control and operands, applies
// MEM/WB forwarding on the latched sources and counts inserted bubbles.
module id_exe_stage #(
  parameter int WIDTH = 32,
  parameter int RA    = 5,
  parameter int CW    = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             ehold,
  input  logic             dbubble,
  input  logic             dwreg,
  input  logic             dm2reg,
  input  logic             dwmem,
  input  logic             daluimm,
  input  logic [3:0]       daluc,
  input  logic [WIDTH-1:0] dqa,
  input  logic [WIDTH-1:0] dqb,
  input  logic [WIDTH-1:0] dimm,
  input  logic [RA-1:0]    drs,
  input  logic [RA-1:0]    drt,
  input  logic [RA-1:0]    drn,
  input  logic             mwreg,
  input  logic [RA-1:0]    mrn,
  input  logic [WIDTH-1:0] malu,
  input  logic             wwreg,
  input  logic [RA-1:0]    wrn,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] eqa,
  output logic [WIDTH-1:0] b,
  output logic [3:0]       ealuc,
  output logic [WIDTH-1:0] eqb,
  output logic             ewreg,
  output logic             em2reg,
  output logic             ewmem,
  output logic [RA-1:0]    ern,
  output logic             evalid,
  output logic [CW-1:0]    bubble_cnt
);

  // Slot protocol: evalid marks a real instruction in the slot; ehold freezes
  // the slot (downstream not ready), dbubble replaces the incoming slot.
  logic             ealuimm;
  logic [WIDTH-1:0] eqa_l;
  logic [WIDTH-1:0] eqb_l;
  logic [WIDTH-1:0] eimm;
  logic [RA-1:0]    ers;
  logic [RA-1:0]    ert;
  logic [WIDTH-1:0] fwd_a;
  logic [WIDTH-1:0] fwd_b;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ewreg      <= 1'b0;
      em2reg     <= 1'b0;
      ewmem      <= 1'b0;
      ealuimm    <= 1'b0;
      ealuc      <= 4'b0;
      eqa_l      <= '0;
      eqb_l      <= '0;
      eimm       <= '0;
      ers        <= '0;
      ert        <= '0;
      ern        <= '0;
      evalid     <= 1'b0;
      bubble_cnt <= '0;
    end else if (!ehold) begin
      if (dbubble) begin
        ewreg   <= 1'b0;
        em2reg  <= 1'b0;
        ewmem   <= 1'b0;
        ealuimm <= 1'b0;
        ealuc   <= 4'b0;
        eqa_l   <= '0;
        eqb_l   <= '0;
        eimm    <= '0;
        ers     <= '0;
        ert     <= '0;
        ern     <= '0;
        evalid  <= 1'b0;
        if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + CW'(1);
      end else begin
        ewreg   <= dwreg;
        em2reg  <= dm2reg;
        ewmem   <= dwmem;
        ealuimm <= daluimm;
        ealuc   <= daluc;
        eqa_l   <= dqa;
        eqb_l   <= dqb;
        eimm    <= dimm;
        ers     <= drs;
        ert     <= drt;
        ern     <= drn;
        evalid  <= 1'b1;
      end
    end
  end

  // MEM result is newer than WB, so it wins; register 0 is never forwarded.
  always_comb begin
    fwd_a = eqa_l;
    if (mwreg && (mrn == ers) && (ers != '0))      fwd_a = malu;
    else if (wwreg && (wrn == ers) && (ers != '0)) fwd_a = wdata;
    fwd_b = eqb_l;
    if (mwreg && (mrn == ert) && (ert != '0))      fwd_b = malu;
    else if (wwreg && (wrn == ert) && (ert != '0)) fwd_b = wdata;
  end

  assign eqa = fwd_a;
  assign eqb = fwd_b;
  assign b   = ealuimm ? eimm : fwd_b;

endmodule

// File: tb/tb_id_exe_stage.sv
// Self-checking bench for id_exe_stage: scoreboard queues filled at drive
// time, popped and compared one cycle later; directed forwarding/hold checks.
module tb_id_exe_stage;
  localparam int WIDTH = 32;
  localparam int RA    = 5;
  localparam int CW    = 4;

  logic             clk, clrn, ehold, dbubble;
  logic             dwreg, dm2reg, dwmem, daluimm;
  logic [3:0]       daluc;
  logic [WIDTH-1:0] dqa, dqb, dimm;
  logic [RA-1:0]    drs, drt, drn;
  logic             mwreg, wwreg;
  logic [RA-1:0]    mrn, wrn;
  logic [WIDTH-1:0] malu, wdata;
  logic [WIDTH-1:0] eqa, b, eqb;
  logic [3:0]       ealuc;
  logic             ewreg, em2reg, ewmem, evalid;
  logic [RA-1:0]    ern;
  logic [CW-1:0]    bubble_cnt;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [12:0]      ctl_q[$];
  logic [CW-1:0]    exp_cnt;
  logic [WIDTH-1:0] e_a, e_b, e_qb;
  logic [12:0]      e_c;

  id_exe_stage #(.WIDTH(WIDTH), .RA(RA), .CW(CW)) dut (
    .clk(clk), .clrn(clrn), .ehold(ehold), .dbubble(dbubble),
    .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem), .daluimm(daluimm),
    .daluc(daluc), .dqa(dqa), .dqb(dqb), .dimm(dimm),
    .drs(drs), .drt(drt), .drn(drn),
    .mwreg(mwreg), .mrn(mrn), .malu(malu),
    .wwreg(wwreg), .wrn(wrn), .wdata(wdata),
    .eqa(eqa), .b(b), .ealuc(ealuc), .eqb(eqb),
    .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem), .ern(ern),
    .evalid(evalid), .bubble_cnt(bubble_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drivers
  task automatic drive_id(input logic wreg, m2reg, wmem, aluimm,
                          input logic [3:0] aluc,
                          input logic [WIDTH-1:0] qa, qb, imm,
                          input logic [RA-1:0] rs, rt, rn);
    dbubble = 1'b0;
    dwreg = wreg; dm2reg = m2reg; dwmem = wmem; daluimm = aluimm;
    daluc = aluc; dqa = qa; dqb = qb; dimm = imm;
    drs = rs; drt = rt; drn = rn;
    exp_q.push_back(qa);
    exp_q.push_back(aluimm ? imm : qb);
    exp_q.push_back(qb);
    ctl_q.push_back({1'b1, wreg, m2reg, wmem, aluc, rn});
  endtask

  task automatic drive_bubble();
    dbubble = 1'b1;
    dwreg = 1'b1; dm2reg = 1'b1; dwmem = 1'b1; daluimm = 1'b1;
    daluc = 4'hF; drn = 5'd7; drs = 5'd3; drt = 5'd4;
    dqa = $urandom; dqb = $urandom; dimm = $urandom;
    exp_q.push_back('0);
    exp_q.push_back('0);
    exp_q.push_back('0);
    ctl_q.push_back(13'b0);
    if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
  endtask

  task automatic test_reset();
    clrn = 1'b0; ehold = 1'b0; dbubble = 1'b0;
    dwreg = 0; dm2reg = 0; dwmem = 0; daluimm = 0; daluc = 0;
    dqa = 0; dqb = 0; dimm = 0; drs = 0; drt = 0; drn = 0;
    mwreg = 0; mrn = 0; malu = 0; wwreg = 0; wrn = 0; wdata = 0;
    exp_cnt = '0;
    tick(); tick();
    clrn = 1'b1;
    drive_id(1, 1, 0, 0, 4'b0110, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 5'd1, 5'd2, 5'd9);
    tick();
    e_a = exp_q.pop_front(); e_b = exp_q.pop_front(); e_qb = exp_q.pop_front(); e_c = ctl_q.pop_front();
    total++;
    if ({eqa, b, eqb} !== {e_a, e_b, e_qb}) begin
      bad++; $display("FAIL pre_reset_data got %h %h %h exp %h %h %h", eqa, b, eqb, e_a, e_b, e_qb);
    end
    total++;
    if ({evalid, ewreg, em2reg, ewmem, ealuc, ern} !== e_c) begin
      bad++; $display("FAIL pre_reset_ctl got %h exp %h", {evalid, ewreg, em2reg, ewmem, ealuc, ern}, e_c);
    end
    // asynchronous reset, checked before the next clock edge
    clrn = 1'b0;
    #1;
    total++;
    if ({eqa, b, eqb} !== {3*WIDTH{1'b0}}) begin
      bad++; $display("FAIL async_reset_data got %h %h %h exp 0", eqa, b, eqb);
    end
    total++;
    if ({evalid, ewreg, em2reg, ewmem, ealuc, ern, bubble_cnt} !== 17'b0) begin
      bad++; $display("FAIL async_reset_ctl got %h exp 0", {evalid, ewreg, em2reg, ewmem, ealuc, ern, bubble_cnt});
    end
    clrn = 1'b1;
    drive_id(0, 0, 0, 0, 4'b0010, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3);
    tick();
    e_a = exp_q.pop_front(); e_b = exp_q.pop_front(); e_qb = exp_q.pop_front(); e_c = ctl_q.pop_front();
    total++;
    if ({eqa, b, ealuc, evalid} !== {32'd5, 32'd7, 4'b0010, 1'b1}) begin
      bad++; $display("FAIL first_add got eqa=%0d b=%0d aluc=%b v=%b exp 5 7 0010 1", eqa, b, ealuc, evalid);
    end
    total++;
    if ({evalid, ewreg, em2reg, ewmem, ealuc, ern} !== e_c || eqb !== e_qb) begin
      bad++; $display("FAIL first_add_ctl got %h eqb=%h exp %h %h", {evalid, ewreg, em2reg, ewmem, ealuc, ern}, eqb, e_c, e_qb);
    end
  endtask

  task automatic test_imm();
    drive_id(1, 0, 0, 1, 4'b0010, 32'd0, 32'd9, 32'hFFFF_FFFC, 5'd0, 5'd0, 5'd8);
    tick();
    e_a = exp_q.pop_front(); e_b = exp_q.pop_front(); e_qb = exp_q.pop_front(); e_c = ctl_q.pop_front();
    total++;
    if (b !== e_b || eqb !== e_qb || eqa !== e_a) begin
      bad++; $display("FAIL imm_select got b=%h eqb=%h eqa=%h exp %h %h %h", b, eqb, eqa, e_b, e_qb, e_a);
    end
    total++;
    if ({evalid, ewreg, em2reg, ewmem, ealuc, ern} !== e_c) begin
      bad++; $display("FAIL imm_ctl got %h exp %h", {evalid, ewreg, em2reg, ewmem, ealuc, ern}, e_c);
    end
  endtask

  task automatic test_forwarding();
    drive_id(0, 0, 0, 0, 4'b0010, 32'd11, 32'd12, 32'd0, 5'd3, 5'd3, 5'd5);
    tick();
    e_a = exp_q.pop_front(); e_b = exp_q.pop_front(); e_qb = exp_q.pop_front(); e_c = ctl_q.pop_front();
    total++;
    if ({eqa, b, eqb} !== {e_a, e_b, e_qb}) begin
      bad++; $display("FAIL fwd_idle got %h %h %h exp %h %h %h", eqa, b, eqb, e_a, e_b, e_qb);
    end
    mwreg = 1; mrn = 5'd3; malu = 32'd100; wwreg = 1; wrn = 5'd3; wdata = 32'd200;
    #1;
    total++;
    if ({eqa, b, eqb} !== {32'd100, 32'd100, 32'd100}) begin
      bad++; $display("FAIL fwd_mem_priority got %0d %0d %0d exp 100 100 100", eqa, b, eqb);
    end
    mwreg = 0;
    #1;
    total++;
    if ({eqa, eqb} !== {32'd200, 32'd200}) begin
      bad++; $display("FAIL fwd_wb got %0d %0d exp 200 200", eqa, eqb);
    end
    wwreg = 0; mwreg = 1; mrn = 5'd4;
    #1;
    total++;
    if ({eqa, eqb} !== {32'd11, 32'd12}) begin
      bad++; $display("FAIL fwd_other_dest got %0d %0d exp 11 12", eqa, eqb);
    end
    // register 0 sources with both stages writing register 0
    mwreg = 1; mrn = 5'd0; wwreg = 1; wrn = 5'd0;
    drive_id(0, 0, 0, 0, 4'b0010, 32'd22, 32'd33, 32'd0, 5'd0, 5'd0, 5'd5);
    tick();
    e_a = exp_q.pop_front(); e_b = exp_q.pop_front(); e_qb = exp_q.pop_front(); e_c = ctl_q.pop_front();
    total++;
    if ({eqa, b, eqb} !== {e_a, e_b, e_qb}) begin
      bad++; $display("FAIL fwd_reg0 got %h %h %h exp %h %h %h", eqa, b, eqb, e_a, e_b, e_qb);
    end
    mwreg = 0; wwreg = 0;
  endtask

  task automatic test_bubble();
    for (int i = 0; i < 3; i++) begin
      drive_bubble();
      tick();
      e_a = exp_q.pop_front(); e_b = exp_q.pop_front(); e_qb = exp_q.pop_front(); e_c = ctl_q.pop_front();
      total++;
      if ({evalid, ewreg, em2reg, ewmem, ealuc, ern} !== e_c || {eqa, b, eqb} !== {e_a, e_b, e_qb}) begin
        bad++; $display("FAIL bubble_slot[%0d] got ctl=%h eqa=%h b=%h exp ctl=%h 0", i, {evalid, ewreg, em2reg, ewmem, ealuc, ern}, eqa, b, e_c);
      end
      total++;
      if (bubble_cnt !== exp_cnt) begin
        bad++; $display("FAIL bubble_cnt[%0d] got %0d exp %0d", i, bubble_cnt, exp_cnt);
      end
    end
    dbubble = 0;
  endtask

  task automatic test_hold();
    drive_id(1, 0, 0, 0, 4'b0010, 32'd5, 32'd6, 32'd0, 5'd0, 5'd0, 5'd2);
    tick();
    e_a = exp_q.pop_front(); e_b = exp_q.pop_front(); e_qb = exp_q.pop_front(); e_c = ctl_q.pop_front();
    ehold = 1; dbubble = 1; dqa = 32'd77;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (eqa !== 32'd5 || evalid !== 1'b1 || bubble_cnt !== exp_cnt || ewreg !== 1'b1) begin
        bad++; $display("FAIL hold[%0d] got eqa=%0d v=%b cnt=%0d wreg=%b exp 5 1 %0d 1", i, eqa, evalid, bubble_cnt, ewreg, exp_cnt);
      end
    end
    ehold = 0; dbubble = 0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      drive_id(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
               $urandom, $urandom, $urandom,
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      tick();
      e_a = exp_q.pop_front(); e_b = exp_q.pop_front(); e_qb = exp_q.pop_front(); e_c = ctl_q.pop_front();
      total++;
      if ({eqa, b, eqb} !== {e_a, e_b, e_qb} || {evalid, ewreg, em2reg, ewmem, ealuc, ern} !== e_c) begin
        bad++; $display("FAIL b2b[%0d] got %h %h %h %h exp %h %h %h %h", i, eqa, b, eqb,
                        {evalid, ewreg, em2reg, ewmem, ealuc, ern}, e_a, e_b, e_qb, e_c);
      end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      drive_bubble();
      tick();
      e_a = exp_q.pop_front(); e_b = exp_q.pop_front(); e_qb = exp_q.pop_front(); e_c = ctl_q.pop_front();
      total++;
      if (bubble_cnt !== exp_cnt || evalid !== 1'b0) begin
        bad++; $display("FAIL sat_cnt[%0d] got %0d v=%b exp %0d 0", i, bubble_cnt, evalid, exp_cnt);
      end
    end
    dbubble = 0;
    total++;
    if (bubble_cnt !== 4'd15) begin
      bad++; $display("FAIL sat_final got %0d exp 15", bubble_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_imm();
    test_forwarding();
    test_bubble();
    test_hold();
    test_back_to_back();
    test_saturation();
    total++;
    if (exp_q.size() != 0 || ctl_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain got %0d/%0d left exp 0", exp_q.size(), ctl_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
